// File: rtl/connect_n_game_core.sv
`default_nettype none
// ============================================================================
// Module   : connect_n_game_core
// Purpose  : Connect-N board, cursor and turn engine with fixed-latency scan
// Revision : 1.0  initial release
// ============================================================================
module connect_n_game_core #(
   parameter int  COLS    = 7,
   parameter int  ROWS    = 6,
   parameter int  WIN_LEN = 4,
   parameter int  WRAP    = 1,
   localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          move_left,
   input  logic          move_right,
   input  logic          drop_piece,
   input  logic [CW-1:0] rd_col,
   input  logic [RW-1:0] rd_row,
   output logic [1:0]    rd_cell,
   output logic [CW-1:0] cursor,
   output logic          cur_player,
   output logic          busy,
   output logic          game_over,
   output logic [1:0]    winner
);

   localparam int HW = $clog2(ROWS + 1);
   localparam int NW = $clog2(COLS * ROWS + 1);
   localparam int SW = $clog2(WIN_LEN);

   localparam logic [CW-1:0]     CUR_RESET = CW'(COLS / 2);
   localparam logic [CW-1:0]     CUR_MAX   = CW'(COLS - 1);
   localparam logic [HW-1:0]     H_FULL    = HW'(ROWS);
   localparam logic [NW-1:0]     N_CELLS   = NW'(COLS * ROWS);
   localparam logic [SW-1:0]     STEP_LAST = SW'(WIN_LEN - 1);
   localparam logic [4:0]        RUN_WIN   = 5'(WIN_LEN);
   localparam logic signed [7:0] COLS_S    = 8'(COLS);
   localparam logic signed [7:0] ROWS_S    = 8'(ROWS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DROP   = 3'd1,
      S_CHECK  = 3'd2,
      S_RESULT = 3'd3,
      S_OVER   = 3'd4
   } state_t;

   state_t        state_q,  state_d;
   logic [1:0]    board_q  [COLS][ROWS];
   logic [1:0]    board_d  [COLS][ROWS];
   logic [HW-1:0] height_q [COLS];
   logic [HW-1:0] height_d [COLS];
   logic [NW-1:0] count_q,  count_d;
   logic [CW-1:0] cursor_q, cursor_d;
   logic          player_q, player_d;
   logic          over_q,   over_d;
   logic [1:0]    winner_q, winner_d;
   logic [CW-1:0] col_q,    col_d;
   logic [RW-1:0] row_q,    row_d;
   logic [2:0]    dir_q,    dir_d;
   logic [SW-1:0] step_q,   step_d;
   logic [4:0]    run_q,    run_d;
   logic          active_q, active_d;
   logic          win_q,    win_d;
   logic [2:0]    prev_q,   prev_d;

   logic                ev_left, ev_right, ev_drop;
   logic [1:0]          piece;
   logic signed [7:0]   col_x, row_x, step_x, px, py;
   logic                in_range, probe_match;
   logic [1:0]          probe_cell;
   logic [4:0]          run_next;

   assign ev_left  = move_left  & ~prev_q[0];
   assign ev_right = move_right & ~prev_q[1];
   assign ev_drop  = drop_piece & ~prev_q[2];
   assign prev_d   = {drop_piece, move_right, move_left};
   assign piece    = player_q ? 2'b10 : 2'b01;

   // Probe location for the current half-direction and step
   always_comb begin
      col_x  = 8'(col_q);
      row_x  = 8'(row_q);
      step_x = 8'(step_q);
      px     = col_x;
      py     = row_x;
      case (dir_q)
         3'd0:    px = col_x - step_x;
         3'd1:    px = col_x + step_x;
         3'd2:    py = row_x - step_x;
         3'd3:    py = row_x + step_x;
         3'd4:    begin px = col_x - step_x; py = row_x - step_x; end
         3'd5:    begin px = col_x + step_x; py = row_x + step_x; end
         3'd6:    begin px = col_x - step_x; py = row_x + step_x; end
         default: begin px = col_x + step_x; py = row_x - step_x; end
      endcase
      in_range   = !px[7] && (px < COLS_S) && !py[7] && (py < ROWS_S);
      probe_cell = 2'b00;
      if (in_range) begin
         probe_cell = board_q[px[CW-1:0]][py[RW-1:0]];
      end
      probe_match = active_q && (probe_cell == piece);
      run_next    = run_q + 5'(probe_match);
   end

   always_comb begin
      state_d  = state_q;
      board_d  = board_q;
      height_d = height_q;
      count_d  = count_q;
      cursor_d = cursor_q;
      player_d = player_q;
      over_d   = over_q;
      winner_d = winner_q;
      col_d    = col_q;
      row_d    = row_q;
      dir_d    = dir_q;
      step_d   = step_q;
      run_d    = run_q;
      active_d = active_q;
      win_d    = win_q;

      case (state_q)
         S_IDLE: begin
            if (ev_drop) begin
               if (height_q[cursor_q] != H_FULL) begin
                  state_d = S_DROP;
                  col_d   = cursor_q;
                  row_d   = height_q[cursor_q][RW-1:0];
               end
            end else if (ev_left && !ev_right) begin
               if (cursor_q == '0) begin
                  cursor_d = (WRAP != 0) ? CUR_MAX : cursor_q;
               end else begin
                  cursor_d = cursor_q - CW'(1);
               end
            end else if (ev_right && !ev_left) begin
               if (cursor_q == CUR_MAX) begin
                  cursor_d = (WRAP != 0) ? '0 : cursor_q;
               end else begin
                  cursor_d = cursor_q + CW'(1);
               end
            end
         end

         S_DROP: begin
            board_d[col_q][row_q] = piece;
            height_d[col_q]       = height_q[col_q] + HW'(1);
            count_d               = count_q + NW'(1);
            dir_d                 = 3'd0;
            step_d                = SW'(1);
            run_d                 = 5'd1;
            active_d              = 1'b1;
            win_d                 = 1'b0;
            state_d               = S_CHECK;
         end

         // A mismatch masks the rest of the half-direction but its cycles still run
         S_CHECK: begin
            if (step_q == STEP_LAST) begin
               step_d   = SW'(1);
               active_d = 1'b1;
               if (dir_q[0]) begin
                  if (run_next >= RUN_WIN) begin
                     win_d = 1'b1;
                  end
                  run_d = 5'd1;
               end else begin
                  run_d = run_next;
               end
               if (dir_q == 3'd7) begin
                  state_d = S_RESULT;
               end else begin
                  dir_d = dir_q + 3'd1;
               end
            end else begin
               step_d   = step_q + SW'(1);
               active_d = probe_match;
               run_d    = run_next;
            end
         end

         S_RESULT: begin
            if (win_q) begin
               over_d   = 1'b1;
               winner_d = piece;
               state_d  = S_OVER;
            end else if (count_q == N_CELLS) begin
               over_d   = 1'b1;
               winner_d = 2'b00;
               state_d  = S_OVER;
            end else begin
               player_d = ~player_q;
               state_d  = S_IDLE;
            end
         end

         S_OVER: begin
            if (ev_drop) begin
               for (int c = 0; c < COLS; c++) begin
                  height_d[c] = '0;
                  for (int r = 0; r < ROWS; r++) begin
                     board_d[c][r] = 2'b00;
                  end
               end
               count_d  = '0;
               cursor_d = CUR_RESET;
               player_d = 1'b0;
               over_d   = 1'b0;
               winner_d = 2'b00;
               state_d  = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         for (int c = 0; c < COLS; c++) begin
            height_q[c] <= '0;
            for (int r = 0; r < ROWS; r++) begin
               board_q[c][r] <= 2'b00;
            end
         end
         count_q  <= '0;
         cursor_q <= CUR_RESET;
         player_q <= 1'b0;
         over_q   <= 1'b0;
         winner_q <= 2'b00;
         col_q    <= '0;
         row_q    <= '0;
         dir_q    <= 3'd0;
         step_q   <= SW'(1);
         run_q    <= 5'd1;
         active_q <= 1'b1;
         win_q    <= 1'b0;
         prev_q   <= 3'b111;
      end else begin
         state_q  <= state_d;
         board_q  <= board_d;
         height_q <= height_d;
         count_q  <= count_d;
         cursor_q <= cursor_d;
         player_q <= player_d;
         over_q   <= over_d;
         winner_q <= winner_d;
         col_q    <= col_d;
         row_q    <= row_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         run_q    <= run_d;
         active_q <= active_d;
         win_q    <= win_d;
         prev_q   <= prev_d;
      end
   end

   always_comb begin
      rd_cell = 2'b00;
      if (({1'b0, rd_col} < (CW+1)'(COLS)) && ({1'b0, rd_row} < (RW+1)'(ROWS))) begin
         rd_cell = board_q[rd_col][rd_row];
      end
   end

   assign cursor     = cursor_q;
   assign cur_player = player_q;
   assign busy       = (state_q == S_DROP) || (state_q == S_CHECK) || (state_q == S_RESULT);
   assign game_over  = over_q;
   assign winner     = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_connect_n_game_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_connect_n_game_core
// Purpose  : Directed, table-driven bench for connect_n_game_core
// Revision : 1.0  initial release
// ============================================================================
module tb_connect_n_game_core;

   typedef struct {
      logic l;
      logic r;
      int   ea;
      int   eb;
   } cur_vec_t;

   typedef struct {
      int col;
      int busy;
      int cp;
      int go;
      int win;
   } drop_vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       move_left = 1'b0;
   logic       move_right = 1'b0;
   logic       drop_piece = 1'b0;

   logic [2:0] rd_col_a = '0, rd_row_a = '0, rd_col_b = '0, rd_row_b = '0;
   logic [1:0] rd_col_c = '0;
   logic       rd_row_c = 1'b0;

   logic [1:0] cell_out_a, cell_out_b, cell_out_c;
   logic [2:0] cursor_a, cursor_b;
   logic [1:0] cursor_c;
   logic       cp_a, cp_b, cp_c, busy_a, busy_b, busy_c, go_a, go_b, go_c;
   logic [1:0] win_a, win_b, win_c;

   int n_cmp = 0;
   int n_bad = 0;
   int mcur  = 3;
   int mcur_c = 1;

   int vcol [6]  = '{0, 1, 0, 1, 0, 1};
   int dcol [11] = '{2, 1, 3, 2, 4, 3, 4, 4, 0, 4, 0};
   int hcol [8]  = '{0, 0, 1, 1, 3, 3, 4, 4};
   int ccol [6]  = '{0, 1, 2, 0, 1, 2};

   cur_vec_t  cv [15];
   drop_vec_t dq [$];
   drop_vec_t cq [$];

   connect_n_game_core #(.COLS(7), .ROWS(6), .WIN_LEN(4), .WRAP(1)) dut_a (
      .clk(clk), .rst(rst), .move_left(move_left), .move_right(move_right),
      .drop_piece(drop_piece), .rd_col(rd_col_a), .rd_row(rd_row_a),
      .rd_cell(cell_out_a), .cursor(cursor_a), .cur_player(cp_a),
      .busy(busy_a), .game_over(go_a), .winner(win_a));

   connect_n_game_core #(.COLS(7), .ROWS(6), .WIN_LEN(4), .WRAP(0)) dut_b (
      .clk(clk), .rst(rst), .move_left(move_left), .move_right(move_right),
      .drop_piece(drop_piece), .rd_col(rd_col_b), .rd_row(rd_row_b),
      .rd_cell(cell_out_b), .cursor(cursor_b), .cur_player(cp_b),
      .busy(busy_b), .game_over(go_b), .winner(win_b));

   connect_n_game_core #(.COLS(3), .ROWS(2), .WIN_LEN(3), .WRAP(1)) dut_c (
      .clk(clk), .rst(rst), .move_left(move_left), .move_right(move_right),
      .drop_piece(drop_piece), .rd_col(rd_col_c), .rd_row(rd_row_c),
      .rd_cell(cell_out_c), .cursor(cursor_c), .cur_player(cp_c),
      .busy(busy_c), .game_over(go_c), .winner(win_c));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic press(input logic l, input logic r);
      @(negedge clk);
      move_left  = l;
      move_right = r;
      @(negedge clk);
      move_left  = 1'b0;
      move_right = 1'b0;
   endtask

   task automatic cell_a(input int c, input int r, output int v);
      rd_col_a = 3'(c);
      rd_row_a = 3'(r);
      #1;
      v = int'(cell_out_a);
   endtask

   task automatic cell_c(input int c, input int r, output int v);
      rd_col_c = 2'(c);
      rd_row_c = 1'(r);
      #1;
      v = int'(cell_out_c);
   endtask

   // One drop press, then count busy cycles of the 7x6 and 3x2 cores
   task automatic do_drop(output int ba, output int bc);
      @(negedge clk);
      drop_piece = 1'b1;
      @(negedge clk);
      drop_piece = 1'b0;
      ba = 0;
      bc = 0;
      for (int i = 0; i < 100 && (busy_a || busy_c); i++) begin
         if (busy_a) ba++;
         if (busy_c) bc++;
         @(negedge clk);
      end
      if (busy_a || busy_c) chk("busy_timeout", 1, 0);
   endtask

   task automatic drop_a(input drop_vec_t v, input int idx);
      int ba, bc;
      if (v.col >= 0) begin
         repeat ((v.col - mcur + 7) % 7) press(1'b0, 1'b1);
         mcur = v.col;
      end
      do_drop(ba, bc);
      chk($sformatf("a_drop%0d_busy_cycles", idx), ba, v.busy);
      chk($sformatf("a_drop%0d_cur_player", idx), int'(cp_a), v.cp);
      chk($sformatf("a_drop%0d_game_over", idx), int'(go_a), v.go);
      chk($sformatf("a_drop%0d_winner", idx), int'(win_a), v.win);
      if (v.col < 0) begin
         mcur = 3;
         chk($sformatf("a_drop%0d_clear_cursor", idx), int'(cursor_a), 3);
      end
   endtask

   task automatic drop_c(input drop_vec_t v, input int idx);
      int ba, bc;
      repeat ((v.col - mcur_c + 3) % 3) press(1'b0, 1'b1);
      mcur_c = v.col;
      do_drop(ba, bc);
      chk($sformatf("c_drop%0d_busy_cycles", idx), bc, v.busy);
      chk($sformatf("c_drop%0d_cur_player", idx), int'(cp_c), v.cp);
      chk($sformatf("c_drop%0d_game_over", idx), int'(go_c), v.go);
      chk($sformatf("c_drop%0d_winner", idx), int'(win_c), v.win);
   endtask

   initial begin
      int v, nz, ba, bc;

      cv[0]  = '{1'b1, 1'b0, 2, 2};
      cv[1]  = '{1'b1, 1'b0, 1, 1};
      cv[2]  = '{1'b1, 1'b0, 0, 0};
      cv[3]  = '{1'b1, 1'b0, 6, 0};
      cv[4]  = '{1'b1, 1'b1, 6, 0};
      cv[5]  = '{1'b0, 1'b1, 0, 1};
      cv[6]  = '{1'b0, 1'b1, 1, 2};
      cv[7]  = '{1'b0, 1'b1, 2, 3};
      cv[8]  = '{1'b0, 1'b1, 3, 4};
      cv[9]  = '{1'b0, 1'b1, 4, 5};
      cv[10] = '{1'b0, 1'b1, 5, 6};
      cv[11] = '{1'b0, 1'b1, 6, 6};
      cv[12] = '{1'b1, 1'b0, 5, 5};
      cv[13] = '{1'b1, 1'b0, 4, 4};
      cv[14] = '{1'b1, 1'b0, 3, 3};

      for (int i = 0; i < 6; i++) dq.push_back('{3, 26, (i + 1) % 2, 0, 0});
      dq.push_back('{3, 0, 0, 0, 0});
      for (int i = 0; i < 6; i++) dq.push_back('{vcol[i], 26, (i + 1) % 2, 0, 0});
      dq.push_back('{0, 26, 0, 1, 1});
      dq.push_back('{-1, 0, 0, 0, 0});
      for (int i = 0; i < 11; i++) dq.push_back('{dcol[i], 26, (i + 1) % 2, 0, 0});
      dq.push_back('{3, 26, 1, 1, 2});
      dq.push_back('{-1, 0, 0, 0, 0});
      for (int i = 0; i < 8; i++) dq.push_back('{hcol[i], 26, (i + 1) % 2, 0, 0});
      dq.push_back('{2, 26, 0, 1, 1});
      dq.push_back('{-1, 0, 0, 0, 0});

      for (int i = 0; i < 5; i++) cq.push_back('{ccol[i], 18, (i + 1) % 2, 0, 0});
      cq.push_back('{ccol[5], 18, 1, 1, 0});

      // Reset with drop held through release
      drop_piece = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("held_drop_busy_1", int'(busy_a), 0);
      @(negedge clk);
      chk("held_drop_busy_2", int'(busy_a), 0);
      drop_piece = 1'b0;
      @(negedge clk);
      chk("rst_cursor_a", int'(cursor_a), 3);
      chk("rst_cursor_b", int'(cursor_b), 3);
      chk("rst_cursor_c", int'(cursor_c), 1);
      chk("rst_cur_player", int'(cp_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_game_over", int'(go_a), 0);
      chk("rst_winner", int'(win_a), 0);
      nz = 0;
      for (int c = 0; c < 7; c++) begin
         for (int r = 0; r < 6; r++) begin
            cell_a(c, r, v);
            if (v != 0) nz++;
         end
      end
      chk("rst_board_nonempty_cells", nz, 0);

      for (int i = 0; i < 15; i++) begin
         press(cv[i].l, cv[i].r);
         chk($sformatf("cursor%0d_wrap", i), int'(cursor_a), cv[i].ea);
         chk($sformatf("cursor%0d_sat", i), int'(cursor_b), cv[i].eb);
      end
      mcur = 3;

      for (int i = 0; i < dq.size(); i++) begin
         drop_a(dq[i], i);
         if (i == 6) begin
            cell_a(3, 0, v);
            chk("full_col_cell_3_0", v, 1);
            cell_a(3, 3, v);
            chk("full_col_cell_3_3", v, 2);
            cell_a(3, 5, v);
            chk("full_col_cell_3_5", v, 2);
         end
         if (i == 13) begin
            press(1'b1, 1'b0);
            chk("over_move_ignored", int'(cursor_a), 0);
            cell_a(0, 3, v);
            chk("vert_win_cell_0_3", v, 1);
         end
         if (i == 14) begin
            cell_a(0, 0, v);
            chk("clear_cell_0_0", v, 0);
         end
         if (i == 26) begin
            cell_a(3, 2, v);
            chk("diag_cell_3_2", v, 2);
            cell_a(7, 0, v);
            chk("rd_col_out_of_range", v, 0);
            cell_a(0, 6, v);
            chk("rd_row_out_of_range", v, 0);
         end
      end

      // Drawn 3x2 board
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mcur = 3;
      mcur_c = 1;
      chk("c_rst_cursor", int'(cursor_c), 1);
      for (int i = 0; i < cq.size(); i++) drop_c(cq[i], i);
      cell_c(1, 1, v);
      chk("c_cell_1_1", v, 1);
      cell_c(2, 1, v);
      chk("c_cell_2_1", v, 2);
      cell_c(3, 0, v);
      chk("c_rd_col_out_of_range", v, 0);

      do_drop(ba, bc);
      chk("c_clear_busy_cycles", bc, 0);
      chk("c_clear_game_over", int'(go_c), 0);
      chk("c_clear_cursor", int'(cursor_c), 1);

      // Reset in the middle of the scan
      @(negedge clk);
      drop_piece = 1'b1;
      @(negedge clk);
      drop_piece = 1'b0;
      repeat (4) @(negedge clk);
      chk("c_midcheck_busy", int'(busy_c), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy_c", int'(busy_c), 0);
      chk("midrst_cursor_c", int'(cursor_c), 1);
      chk("midrst_cur_player_c", int'(cp_c), 0);
      chk("midrst_game_over_c", int'(go_c), 0);
      chk("midrst_winner_c", int'(win_c), 0);
      cell_c(1, 0, v);
      chk("midrst_cell_c_1_0", v, 0);
      chk("midrst_busy_a", int'(busy_a), 0);
      chk("midrst_cursor_a", int'(cursor_a), 3);
      @(negedge clk);
      chk("midrst_busy_c_after", int'(busy_c), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
